cfg_logic_cluster: RTL and testbench

//  Cluster of N configurable cells, each a K-input LUT plus an optional D flip-flop.
//  A serial configuration chain loads the cells over a valid/ready handshake, under a load FSM.
//  It is the parametrised successor of the single fixed-width logic tile.

---
 rtl/cfg_logic_cluster.sv | 128 ++++++++++++
 tb/tb_cfg_logic_cluster.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_logic_cluster.sv
// Cluster of N cells (K-input LUT plus optional FF) loaded over a serial configuration chain.
// Define CFG_PARITY_EN to append a trailing even-parity bit to every load.
//
// state  | meaning
// IDLE   | after reset, waiting for cfg_start
// LOAD   | shifting configuration bits into the chain
// PARITY | waiting for the trailing parity bit (CFG_PARITY_EN)
// ACTIVE | configuration live, cells drive out
// ERROR  | parity mismatch, held until cfg_start or reset (CFG_PARITY_EN)

module cfg_logic_cluster #(
  parameter int K = 5,
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           cfg_start,
  input  logic           cfg_valid,
  input  logic           cfg_data,
  output logic           cfg_ready,
  output logic           cfg_sout,
  output logic           cfg_done,
  output logic           cfg_err,
  input  logic [N*K-1:0] lut_in,
  input  logic [N-1:0]   ff_en,
  output logic [N-1:0]   out
);

  localparam int TBL_BITS  = 1 << K;
  localparam int CELL_BITS = TBL_BITS + 1;
  localparam int CFG_BITS  = N * CELL_BITS;
  localparam int CW        = $clog2(CFG_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(CFG_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ACTIVE = 3'd2
`ifdef CFG_PARITY_EN
    ,
    PARITY = 3'd3,
    ERROR  = 3'd4
`endif
  } state_t;

  state_t              state;
  logic [CFG_BITS-1:0] cfg_mem;
  logic [CW-1:0]       cnt;
  logic [N-1:0]        q;
  logic [N-1:0]        d;
  logic                active;
  logic                xfer;

  assign active = (state == ACTIVE);
  assign xfer   = cfg_valid && cfg_ready;

  for (genvar g = 0; g < N; g++) begin : g_cell
    logic [TBL_BITS-1:0] tbl;
    logic                sel;
    assign tbl    = cfg_mem[g*CELL_BITS +: TBL_BITS];
    assign sel    = cfg_mem[g*CELL_BITS + TBL_BITS];
    assign d[g]   = tbl[lut_in[g*K +: K]];
    assign out[g] = active && (sel ? q[g] : d[g]);
  end

`ifndef CFG_PARITY_EN
  assign cfg_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      cfg_mem   <= '0;
      cnt       <= '0;
      q         <= '0;
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_sout  <= 1'b0;
`ifdef CFG_PARITY_EN
      cfg_err   <= 1'b0;
`endif
    end else begin
      // cell FFs only run while the configuration is live
      q <= active ? ((d & ff_en) | (q & ~ff_en)) : '0;
      if (cfg_start) begin
        state     <= LOAD;
        cnt       <= '0;
        cfg_ready <= 1'b1;
        cfg_done  <= 1'b0;
`ifdef CFG_PARITY_EN
        cfg_err   <= 1'b0;
`endif
      end else if (xfer) begin
        case (state)
          LOAD: begin
            cfg_mem  <= {cfg_mem[CFG_BITS-2:0], cfg_data};
            cfg_sout <= cfg_mem[CFG_BITS-1];
            cnt      <= cnt + CW'(1);
            if (cnt == LAST_BIT) begin
`ifdef CFG_PARITY_EN
              state     <= PARITY;
`else
              state     <= ACTIVE;
              cfg_ready <= 1'b0;
              cfg_done  <= 1'b1;
`endif
            end
          end
`ifdef CFG_PARITY_EN
          PARITY: begin
            // parity bit is consumed here and never reaches cfg_sout
            cfg_ready <= 1'b0;
            if (^{cfg_mem, cfg_data}) begin
              state   <= ERROR;
              cfg_err <= 1'b1;
            end else begin
              state    <= ACTIVE;
              cfg_done <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_logic_cluster.sv
// Bench for cfg_logic_cluster (K=2, N=2): directed scenarios plus random traffic against a queue-based model.
// Builds with or without CFG_PARITY_EN.

module tb_cfg_logic_cluster;

  localparam int TK   = 2;
  localparam int TN   = 2;
  localparam int TCB  = 5;
  localparam int TCFG = 10;

  logic       clock = 1'b0;
  logic       reset_n, cfg_start, cfg_valid, cfg_data;
  logic       cfg_ready, cfg_sout, cfg_done, cfg_err;
  logic [3:0] lut_in;
  logic [1:0] ff_en, dout;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  cfg_logic_cluster #(.K(TK), .N(TN)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .cfg_sout  (cfg_sout),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .lut_in    (lut_in),
    .ff_en     (ff_en),
    .out       (dout)
  );

  // Model: chain held as a queue, oldest accepted bit at the front (= chain MSB).
  bit         cfgq[$];
  bit         loading, pwait, live, e_done, e_err, e_sout;
  bit   [1:0] mq;
  int         nbits;
  bit         armed = 1'b0;
  logic [3:0] cur_lut;
  logic [1:0] cur_ff;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_d(input int i, input logic [3:0] lut);
    int idx;
    idx = int'((lut >> (i * TK)) & 4'd3);
    return cfgq[TCFG - 1 - (i * TCB + idx)];
  endfunction

  function automatic bit m_sel(input int i);
    return cfgq[TCFG - 1 - (i * TCB + 4)];
  endfunction

  function automatic logic [1:0] m_out(input logic [3:0] lut);
    logic [1:0] r;
    r = '0;
    if (live)
      for (int i = 0; i < TN; i++) r[i] = m_sel(i) ? mq[i] : m_d(i, lut);
    return r;
  endfunction

  task automatic m_edge(input bit r, input bit s, input bit v, input bit dt,
                        input logic [3:0] lut, input logic [1:0] ff);
    bit [1:0] dn;
    int ones;
    for (int i = 0; i < TN; i++) dn[i] = m_d(i, lut);
    if (!r) begin
      cfgq.delete();
      for (int k = 0; k < TCFG; k++) cfgq.push_back(1'b0);
      loading = 0; pwait = 0; live = 0; e_done = 0; e_err = 0; e_sout = 0; mq = '0; nbits = 0;
    end else begin
      if (live) begin
        for (int i = 0; i < TN; i++) if (ff[i]) mq[i] = dn[i];
      end else begin
        mq = '0;
      end
      if (s) begin
        loading = 1; pwait = 0; live = 0; nbits = 0; e_done = 0; e_err = 0;
      end else if (loading && v) begin
        e_sout = cfgq.pop_front();
        cfgq.push_back(dt);
        nbits++;
        if (nbits == TCFG) begin
          loading = 0;
`ifdef CFG_PARITY_EN
          pwait = 1;
`else
          live = 1;
          e_done = 1;
`endif
        end
      end else if (pwait && v) begin
        ones = int'(dt);
        foreach (cfgq[k]) ones += int'(cfgq[k]);
        pwait = 0;
        if (ones % 2 == 0) begin
          live = 1;
          e_done = 1;
        end else begin
          e_err = 1;
        end
      end
    end
  endtask

  // One clock: drive, check comb outputs mid-cycle, step model at the edge, check registered outputs.
  task automatic cyc(input bit r, input bit s, input bit v, input bit dt);
    reset_n = r; cfg_start = s; cfg_valid = v; cfg_data = dt;
    lut_in = cur_lut; ff_en = cur_ff;
    #1;
    if (armed) check("out", dout, m_out(cur_lut));
    @(posedge clock);
    m_edge(r, s, v, dt, cur_lut, cur_ff);
    #1;
    armed = 1'b1;
    check("ready", cfg_ready, loading || pwait);
    check("done", cfg_done, e_done);
    check("err", cfg_err, e_err);
    check("sout", cfg_sout, e_sout);
  endtask

  task automatic load_word(input logic [9:0] w, input int gap_at, input int gap_len);
    cyc(1, 1, 0, 0);
    for (int b = 0; b < TCFG; b++) begin
      if (b == gap_at)
        for (int g = 0; g < gap_len; g++) begin
          cyc(1, 0, 0, 0);
          check("gap_done", cfg_done, 0);
          check("gap_ready", cfg_ready, 1);
        end
      cyc(1, 0, 1, w[9-b]);
      if (b == 8) check("done_early", cfg_done, 0);
    end
`ifdef CFG_PARITY_EN
    cyc(1, 0, 1, ^w);
`endif
    check("load_done", cfg_done, 1);
  endtask

  logic [9:0] s1_word;
  logic [9:0] replay;

  initial begin
    s1_word = 10'b1_1000_0_0110;
    cur_lut = '0;
    cur_ff  = '0;
    for (int k = 0; k < TCFG; k++) cfgq.push_back(1'b0);
    loading = 0; pwait = 0; live = 0; e_done = 0; e_err = 0; e_sout = 0; mq = '0; nbits = 0;

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("rst_out", dout, 0);
    check("rst_ready", cfg_ready, 0);

    // registered AND on cell1, comb XOR on cell0
    load_word(s1_word, -1, 0);

    cur_ff = 2'b11;
    cur_lut = 4'b11_01;
    lut_in = cur_lut; ff_en = cur_ff;
    #1;
    check("s2_comb", dout, 2'b01);
    cyc(1, 0, 0, 0);
    check("s2_reg", dout, 2'b11);
    cur_lut = 4'b10_01;
    cyc(1, 0, 0, 0);
    check("s2_and0", dout, 2'b01);
    repeat (20) begin
      cur_lut = 4'($urandom);
      cur_ff  = 2'($urandom);
      cyc(1, 0, 1'($urandom), 1'($urandom));
    end

    // valid gap mid-load
    load_word(s1_word, 4, 3);
    cur_ff = 2'b11;
    cur_lut = 4'b11_01;
    cyc(1, 0, 0, 0);
    check("s3_out", dout, 2'b11);

    // restart after 6 bits, then zero load replays the chain on cfg_sout
    cyc(1, 1, 0, 0);
    for (int b = 0; b < 6; b++) cyc(1, 0, 1, s1_word[9-b]);
    replay = 10'b0110_110000;
    cyc(1, 1, 0, 0);
    for (int b = 0; b < TCFG; b++) begin
      cyc(1, 0, 1, 0);
      check("s4_sout", cfg_sout, replay[9-b]);
      check("s4_out", dout, 0);
    end
`ifdef CFG_PARITY_EN
    cyc(1, 0, 1, 0);
`endif
    check("s4_done", cfg_done, 1);

    // reset after a full load wipes the chain
    load_word(s1_word, -1, 0);
    cur_lut = 4'b11_01;
    cyc(0, 0, 0, 0);
    check("s5_out", dout, 0);
    check("s5_done", cfg_done, 0);
    repeat (3) begin
      cyc(1, 0, 1, 1);
      check("s5_ignored", cfg_ready, 0);
    end
    cyc(1, 1, 0, 0);
    for (int b = 0; b < TCFG; b++) begin
      cyc(1, 0, 1, 1);
      check("s5_mem0", cfg_sout, 0);
    end

`ifdef CFG_PARITY_EN
    cyc(1, 0, 1, ^s1_word);
    load_word(s1_word, -1, 0);
    check("s6_ok_err", cfg_err, 0);
    cyc(1, 1, 0, 0);
    for (int b = 0; b < TCFG; b++) cyc(1, 0, 1, s1_word[9-b]);
    cyc(1, 0, 1, ~(^s1_word));
    check("s6_err", cfg_err, 1);
    check("s6_nodone", cfg_done, 0);
    cur_lut = 4'b11_01;
    repeat (3) begin
      cyc(1, 0, 1, 1);
      check("s6_out0", dout, 0);
    end
    cyc(1, 1, 0, 0);
    check("s6_clear", cfg_err, 0);
`endif

    repeat (3000) begin
      cur_lut = 4'($urandom);
      cur_ff  = 2'($urandom);
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
